// File: rtl/w_ptr_ctrl_ext.sv
// Write-domain controller for the asynchronous FIFO.
// Owns the binary/Gray write pointers, a parametrised read-pointer
// synchroniser, registered full / almost-full / fill-level flags and a
// sticky overflow flag. All state lives in the w_clk domain.
module w_ptr_ctrl_ext #(
    parameter int ADDRESS_SIZE = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_LEVEL  = 14
) (
    input  logic                    w_clk,
    input  logic                    wrst_n,
    input  logic                    w_en,
    input  logic                    w_ovf_clr,
    input  logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE-1:0] w_addr,
    output logic                    w_inc,
    output logic                    w_full,
    output logic                    w_almost_full,
    output logic [ADDRESS_SIZE:0]   w_count,
    output logic                    w_overflow
);

    localparam int AS = ADDRESS_SIZE;
    localparam int PW = ADDRESS_SIZE + 1;
    // Threshold fits in PW bits because AFULL_LEVEL never exceeds the depth.
    localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

    // Gray to binary: XOR prefix running from the MSB downwards.
    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary to Gray: adjacent codes differ in exactly one bit.
    function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // State registers
    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic [PW-1:0] r_sync [SYNC_STAGES];
    logic          r_full;
    logic          r_afull;
    logic [PW-1:0] r_count;
    logic          r_ovf;

    // Next-state wires
    logic          w_accept;
    logic [PW-1:0] w_bnext;
    logic [PW-1:0] w_gnext;
    logic [PW-1:0] w_rq_gray;
    logic [PW-1:0] w_rq_bin;
    logic [PW-1:0] w_full_match;
    logic          w_next_full;
    logic [PW-1:0] w_next_count;
    logic          w_next_afull;
    logic          w_next_ovf;

    // Pointer advance, fill level and flag evaluation for the coming edge.
    always_comb begin
        w_accept     = w_en & ~r_full;
        w_bnext      = r_bin + PW'(w_accept);
        w_gnext      = bin_to_gray(w_bnext);
        w_rq_gray    = r_sync[SYNC_STAGES-1];
        w_rq_bin     = gray_to_bin(w_rq_gray);
        // Full when the next write pointer is one lap ahead of the read
        // pointer: the two Gray MSBs differ, the remaining bits match.
        w_full_match = {~w_rq_gray[AS:AS-1], w_rq_gray[AS-2:0]};
        w_next_full  = (w_gnext == w_full_match);
        // Read pointer never overtakes the write pointer, so the modular
        // difference is the true fill level (at most the depth).
        w_next_count = w_bnext - w_rq_bin;
        w_next_afull = (w_next_count >= AFULL_THR);
    end

    // Sticky overflow: a rejected write sets it and beats a coincident clear.
    always_comb begin
        w_next_ovf = r_ovf;
        if (w_en && r_full) begin
            w_next_ovf = 1'b1;
        end else if (w_ovf_clr) begin
            w_next_ovf = 1'b0;
        end else begin
            w_next_ovf = r_ovf;
        end
    end

    // Write pointers, flags and fill level, cleared to empty on reset.
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_bin   <= w_bnext;
            r_gray  <= w_gnext;
            r_full  <= w_next_full;
            r_afull <= w_next_afull;
            r_count <= w_next_count;
            r_ovf   <= w_next_ovf;
        end
    end

    // Read-pointer synchroniser chain into the write clock domain.
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= r_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_ptr         = r_gray;
    assign w_addr        = r_bin[AS-1:0];
    assign w_inc         = w_accept;
    assign w_full        = r_full;
    assign w_almost_full = r_afull;
    assign w_count       = r_count;
    assign w_overflow    = r_ovf;

endmodule

// File: doc/w_ptr_ctrl_ext.md
Name: w_ptr_ctrl_ext

Overview:
Write-domain controller for the asynchronous FIFO, and the parametrised successor to the existing write-side pointer/full block. It owns:
- the binary and Gray write pointers and the memory write address;
- a configurable-depth synchroniser for the read pointer;
- registered full, almost-full and fill-level outputs;
- a sticky overflow error flag.

It sits in the w_clk domain, between the write client, the dual-port RAM and the read-domain controller.

Parameters:
- ADDRESS_SIZE, 4, RAM address width; FIFO depth = 2**ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits. Legal range 2..16.
- SYNC_STAGES, 2, flops in the r_ptr synchroniser. Legal range 2..4.
- AFULL_LEVEL, 14, fill level (words) at or above which w_almost_full asserts. Legal range 1..2**ADDRESS_SIZE.

Ports:
- w_clk  input  1  write-domain clock; all flops are rising-edge.
- wrst_n  input  1  reset, asynchronous and active-low.
- w_en  input  1  write request from the client.
- w_ovf_clr  input  1  synchronous clear of w_overflow.
- r_ptr  input  ADDRESS_SIZE+1  Gray read pointer from the read domain (unsynchronised).
- w_ptr  output  ADDRESS_SIZE+1  registered Gray write pointer, sent to the read domain.
- w_addr  output  ADDRESS_SIZE  RAM write address = w_bin[ADDRESS_SIZE-1:0].
- w_inc  output  1  combinational RAM write strobe = w_en & !w_full.
- w_full  output  1  registered full flag.
- w_almost_full  output  1  registered almost-full flag.
- w_count  output  ADDRESS_SIZE+1  registered conservative fill level, 0..2**ADDRESS_SIZE.
- w_overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:

Reset (wrst_n low, asynchronous):
- Cleared to 0: w_bin, w_ptr, all synchroniser flops, w_full, w_almost_full, w_count, w_overflow.
- w_addr = 0.
- Reset may be applied mid-operation; all state returns to empty immediately, with no partial-write bookkeeping.

Write pointer:
- w_bnext = w_bin + w_inc, modulo 2**(ADDRESS_SIZE+1).
- w_gnext = w_bnext ^ (w_bnext >> 1).
- Both w_bin and w_ptr register their next values every cycle. w_ptr is a pure flop output with no combinational path, so it is safe to cross domains.
- A write accepted in cycle N updates w_addr and w_ptr at edge N+1.
- Pointer wrap past 2**(ADDRESS_SIZE+1)-1 to 0 is seamless.

Synchroniser:
- r_ptr passes through a SYNC_STAGES-deep flop chain (all stages reset to 0) to give wq_rptr.
- wq_rptr is converted Gray-to-binary to give wq_rbin. This is an XOR prefix from the MSB down.

Full flag (registered):
- next_full = (w_gnext == {~wq_rptr[AS:AS-1], wq_rptr[AS-2:0]}), where AS = ADDRESS_SIZE.
- Assertion is immediate: the write that fills the FIFO in cycle N gives w_full=1 at edge N+1.
- Deassertion is pessimistic. A read-pointer change reaches w_full SYNC_STAGES+1 edges later.

Fill level:
- next_count = w_bnext - wq_rbin, modulo 2**(ADDRESS_SIZE+1).
- The result is at most 2**ADDRESS_SIZE by construction and is registered into w_count.
- Invariant: w_full == (w_count == 2**ADDRESS_SIZE) at every edge.

Almost-full:
- next_afull = (next_count >= AFULL_LEVEL), registered.
- When AFULL_LEVEL = 2**ADDRESS_SIZE, w_almost_full equals w_full.

Overflow:
- w_en & w_full sets w_overflow at the next edge.
- The rejected write does not move the pointer and does not strobe the RAM.
- w_ovf_clr clears the flag at the next edge.
- If set and clear coincide, set wins (flag stays 1).

Simultaneous events:
- If a write is accepted in the same cycle a synchronised read advance arrives, the count is unchanged and the flags are evaluated on next_count.
- This covers the full boundary: the write still fills the FIFO only if the comparison holds.

Test Plan:
1. Reset, then 16 writes with r_ptr held at 0 (ADDRESS_SIZE=4).
   - w_addr runs 0..15 and wraps to 0.
   - w_almost_full rises at the edge where w_count=14.
   - w_full=1 and w_count=16 after the 16th write.
   - w_ptr=5'b11000.
2. While full, hold w_en=1 for 3 cycles.
   - w_inc=0 and w_ptr is unchanged.
   - w_overflow=1 from the first rejected edge onwards.
   - Pulse w_ovf_clr with w_en=0: w_overflow returns to 0 one edge later.
   - With w_en=1 and w_ovf_clr=1 in the same cycle: w_overflow stays 1.
3. From full, change r_ptr (Gray) to 5'b00001, i.e. read binary 1.
   - With SYNC_STAGES=2: w_full falls exactly 3 edges later and w_count becomes 15.
   - Repeat with SYNC_STAGES=3: the fall comes 4 edges later.
4. Wrap test: advance the read pointer in Gray steps so the reads track the writes, for 40 writes.
   - w_bin wraps 31 to 0 without a spurious w_full.
   - w_count stays within 0..16.
   - The invariant w_full == (w_count == 16) is checked every cycle.
5. Assert wrst_n=0 asynchronously mid-burst, between clock edges, with w_count=9.
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release, the first write produces w_addr=0 and then w_ptr=5'b00001.
6. Parameter sweep with ADDRESS_SIZE=2, AFULL_LEVEL=4.
   - w_almost_full and w_full rise on the same edge after the 4th write.
   - Gray w_ptr sequence is 0,1,3,2,6,7,5,4 across the first 8 accepted writes, with intermediate reads to allow progress.
